// File: rtl/cpu6502_pkg.sv
// Shared encodings for the 6502-style datapath and its control FSM.
package cpu6502_pkg;

  // address_select encodings, shared with the control FSM
  localparam logic ADDR_PC   = 1'b0;
  localparam logic ADDR_ZERO = 1'b1;

  // read/write strobe encodings
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Reset vector low byte; the high byte is fetched from RESET_VECTOR + 1
  localparam logic [15:0] RESET_VECTOR = 16'hFFFC;

  // Opcode shown in opcode_reg until the first instruction is latched
  localparam logic [7:0] NOP_OPCODE = 8'hEA;

  // Reset-vector sequencer states; RUN is terminal until reset
  typedef enum logic [1:0] {
    SEQ_VEC_LO = 2'd0,
    SEQ_VEC_HI = 2'd1,
    SEQ_RUN    = 2'd2
  } seq_state_t;

endpackage

// File: rtl/program_counter.sv
// 16-bit program counter with byte-wise loads and a wrapping increment.
// The owner guarantees loads and increment are never asserted together
// for the same byte; if they are, the byte load wins for that byte.
module program_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data,
  input  logic        load_lo,
  input  logic        load_hi,
  input  logic        increment,
  output logic [15:0] pc
);

  logic [15:0] pc_next;

  // Next-value selection: increment first, byte loads override their byte
  always_comb begin
    pc_next = pc;
    if (increment) pc_next = pc + 16'd1;
    if (load_lo)   pc_next[7:0]  = data;
    if (load_hi)   pc_next[15:8] = data;
  end

  // PC register, cleared asynchronously while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= 16'h0000;
    else      pc <= pc_next;
  end

endmodule

// File: rtl/address_unit.sv
// Address unit: reset-vector sequencer, operand registers, and the
// combinational memory address mux.
//
// Handshake: there is no valid/ready pair on the data path. 'ready' is a
// level that rises once the reset vector has been fetched and stays high
// until the next reset; every load/increment strobe is a single-edge
// command that is honoured only while ready is high and ignored otherwise.
module address_unit
  import cpu6502_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        instruction_load,
  input  logic        increment_pc,
  input  logic        dirl_load,
  input  logic        dirh_load,
  input  logic        indirl_load,
  input  logic        indirh_load,
  input  logic        address_select,
  output logic [15:0] address,
  output logic [7:0]  opcode,
  output logic [7:0]  opcode_reg,
  output logic [15:0] pc,
  output logic [15:0] dir_addr,
  output logic [15:0] indir_addr,
  output logic        ready,
  output logic [1:0]  state
);

  seq_state_t state_q;
  seq_state_t state_d;
  logic       run;
  logic [7:0] dirl;
  logic [7:0] dirh;
  logic [7:0] indirl;
  logic [7:0] indirh;

  assign run        = (state_q == SEQ_RUN);
  assign state      = state_q;
  assign opcode     = data_in;
  assign dir_addr   = {dirh, dirl};
  assign indir_addr = {indirh, indirl};

  // The vector bytes go straight into the PC; increments only count in RUN
  program_counter u_program_counter (
    .clk       (clk),
    .rst       (rst),
    .data      (data_in),
    .load_lo   (state_q == SEQ_VEC_LO),
    .load_hi   (state_q == SEQ_VEC_HI),
    .increment (run & increment_pc),
    .pc        (pc)
  );

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SEQ_VEC_LO;
    else      state_q <= state_d;
  end

  // Next state, ready and address mux decoded from the current state
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    address = RESET_VECTOR;
    case (state_q)
      SEQ_VEC_LO: begin
        address = RESET_VECTOR;
        state_d = SEQ_VEC_HI;
      end
      SEQ_VEC_HI: begin
        address = RESET_VECTOR + 16'd1;
        state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        ready   = 1'b1;
        address = (address_select == ADDR_ZERO) ? {8'h00, dirl} : pc;
      end
      default: begin
        state_d = SEQ_VEC_LO;
      end
    endcase
  end

  // Operand and instruction registers, written only once the vector is in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_reg <= NOP_OPCODE;
      dirl       <= 8'h00;
      dirh       <= 8'h00;
      indirl     <= 8'h00;
      indirh     <= 8'h00;
    end else if (run) begin
      if (instruction_load) opcode_reg <= data_in;
      if (dirl_load)        dirl       <= data_in;
      if (dirh_load)        dirh       <= data_in;
      if (indirl_load)      indirl     <= data_in;
      if (indirh_load)      indirh     <= data_in;
    end
  end

endmodule

// File: tb/tb_address_unit.sv
// Self-checking bench for address_unit: hand sequences for the reset and
// wrap corners, a directed table in RUN, and a randomized run against a
// cycle-phase reference model.
module tb_address_unit;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  data_in = 8'h00;
  logic        instruction_load = 1'b0;
  logic        increment_pc = 1'b0;
  logic        dirl_load = 1'b0;
  logic        dirh_load = 1'b0;
  logic        indirl_load = 1'b0;
  logic        indirh_load = 1'b0;
  logic        address_select = 1'b0;
  logic [15:0] address;
  logic [7:0]  opcode;
  logic [7:0]  opcode_reg;
  logic [15:0] pc;
  logic [15:0] dir_addr;
  logic [15:0] indir_addr;
  logic        ready;
  logic [1:0]  dbg_state;

  address_unit dut (
    .clk              (clk),
    .rst              (rst),
    .data_in          (data_in),
    .instruction_load (instruction_load),
    .increment_pc     (increment_pc),
    .dirl_load        (dirl_load),
    .dirh_load        (dirh_load),
    .indirl_load      (indirl_load),
    .indirh_load      (indirh_load),
    .address_select   (address_select),
    .address          (address),
    .opcode           (opcode),
    .opcode_reg       (opcode_reg),
    .pc               (pc),
    .dir_addr         (dir_addr),
    .indir_addr       (indir_addr),
    .ready            (ready),
    .state            (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard compare
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_ctl(input logic il, input logic inc, input logic dl, input logic dh,
                         input logic xl, input logic xh, input logic sel);
    instruction_load = il;
    increment_pc     = inc;
    dirl_load        = dl;
    dirh_load        = dh;
    indirl_load      = xl;
    indirh_load      = xh;
    address_select   = sel;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},     pc, 16'h0000);
    check({tag, "_op"},     {8'h00, opcode_reg}, 16'h00EA);
    check({tag, "_dir"},    dir_addr, 16'h0000);
    check({tag, "_ind"},    indir_addr, 16'h0000);
    check({tag, "_ready"},  {15'h0, ready}, 16'h0000);
    check({tag, "_addr"},   address, 16'hFFFC);
  endtask

  // Reset pulse then vector fetch; 'junk' holds loads/increment high throughout
  task automatic vector_fetch(input logic [7:0] lo, input logic [7:0] hi, input logic junk);
    @(negedge clk);
    set_ctl(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1 check_reset_vals("rst");
    @(negedge clk);
    rst = 1'b1;
    data_in = lo;
    set_ctl(junk, junk, junk, junk, junk, junk, 0);
    #1 check("vec_lo_addr", address, 16'hFFFC);
    @(posedge clk); #1;
    check("vec_hi_addr", address, 16'hFFFD);
    check("vec_hi_ready", {15'h0, ready}, 16'h0000);
    check("vec_hi_pc", pc, {8'h00, lo});
    @(negedge clk);
    data_in = hi;
    @(posedge clk); #1;
    check("run_pc", pc, {hi, lo});
    check("run_ready", {15'h0, ready}, 16'h0001);
    check("run_op", {8'h00, opcode_reg}, 16'h00EA);
    check("run_dir", dir_addr, 16'h0000);
    check("run_ind", indir_addr, 16'h0000);
    check("run_addr", address, {hi, lo});
    @(negedge clk);
    set_ctl(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    logic        il, inc, dl, dh, xl, xh, sel;
    logic [7:0]  d;
    logic [15:0] e_pc;
    logic [7:0]  e_op;
    logic [15:0] e_dir;
    logic [15:0] e_ind;
    logic [15:0] e_addr;
  } vec_t;

  vec_t tbl[8];

  // reference model state (random phase)
  int          m_phase;
  logic [15:0] m_pc;
  logic [7:0]  m_op, m_dl, m_dh, m_xl, m_xh;

  function automatic logic [15:0] model_addr(input logic sel);
    if (m_phase == 0) return 16'hFFFC;
    if (m_phase == 1) return 16'hFFFD;
    return sel ? {8'h00, m_dl} : m_pc;
  endfunction

  logic [1:0] reset_state;

  initial begin
    // Reset vector with loads/increment held high: all ignored
    vector_fetch(8'h34, 8'h12, 1'b1);

    // Directed RUN vectors, starting from pc 1234, op EA, dir/indir 0000
    //          il inc dl dh xl xh sel  d      pc        op     dir       ind       addr
    tbl[0] = '{1, 1, 1, 0, 0, 0, 1, 8'hA9, 16'h1235, 8'hA9, 16'h00A9, 16'h0000, 16'h00A9};
    tbl[1] = '{0, 1, 0, 0, 0, 0, 0, 8'h00, 16'h1236, 8'hA9, 16'h00A9, 16'h0000, 16'h1236};
    tbl[2] = '{0, 0, 1, 0, 0, 0, 1, 8'h80, 16'h1236, 8'hA9, 16'h0080, 16'h0000, 16'h0080};
    tbl[3] = '{0, 0, 0, 1, 0, 0, 0, 8'h12, 16'h1236, 8'hA9, 16'h1280, 16'h0000, 16'h1236};
    tbl[4] = '{0, 0, 0, 0, 1, 0, 1, 8'h55, 16'h1236, 8'hA9, 16'h1280, 16'h0055, 16'h0080};
    tbl[5] = '{0, 1, 0, 0, 0, 1, 0, 8'h66, 16'h1237, 8'hA9, 16'h1280, 16'h6655, 16'h1237};
    tbl[6] = '{1, 1, 1, 1, 1, 1, 1, 8'h3C, 16'h1238, 8'h3C, 16'h3C3C, 16'h3C3C, 16'h003C};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 8'hFF, 16'h1238, 8'h3C, 16'h3C3C, 16'h3C3C, 16'h1238};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_ctl(tbl[i].il, tbl[i].inc, tbl[i].dl, tbl[i].dh, tbl[i].xl, tbl[i].xh, tbl[i].sel);
      data_in = tbl[i].d;
      #1 check($sformatf("t%0d_opcode", i), {8'h00, opcode}, {8'h00, tbl[i].d});
      @(posedge clk); #1;
      check($sformatf("t%0d_pc", i),   pc, tbl[i].e_pc);
      check($sformatf("t%0d_op", i),   {8'h00, opcode_reg}, {8'h00, tbl[i].e_op});
      check($sformatf("t%0d_dir", i),  dir_addr, tbl[i].e_dir);
      check($sformatf("t%0d_ind", i),  indir_addr, tbl[i].e_ind);
      check($sformatf("t%0d_addr", i), address, tbl[i].e_addr);
    end

    // Increment across the 16-bit wrap
    vector_fetch(8'hFE, 8'hFF, 1'b0);
    @(negedge clk);
    increment_pc = 1'b1;
    @(posedge clk); #1 check("wrap_ffff", pc, 16'hFFFF);
    check("wrap_addr_ffff", address, 16'hFFFF);
    @(posedge clk); #1 check("wrap_0000", pc, 16'h0000);
    check("wrap_addr_0000", address, 16'h0000);
    @(negedge clk);
    increment_pc = 1'b0;

    // Mid-operation asynchronous reset, then vector refetch
    vector_fetch(8'h34, 8'h12, 1'b0);
    @(negedge clk);
    set_ctl(1, 1, 1, 1, 1, 1, 0);
    data_in = 8'h77;
    @(posedge clk); #1 check("mid_pc_before", pc, 16'h1235);
    reset_state = dbg_state;
    #2 rst = 1'b0;
    #1 check_reset_vals("mid_async");
    check("mid_state_moved", {15'h0, (dbg_state == reset_state)}, 16'h0000);
    @(posedge clk); #1 check_reset_vals("mid_held");
    @(negedge clk);
    rst = 1'b1;
    data_in = 8'h56;
    @(posedge clk); #1;
    check("mid_re_pc_lo", pc, 16'h0056);
    check("mid_re_addr", address, 16'hFFFD);
    check("mid_re_op", {8'h00, opcode_reg}, 16'h00EA);
    @(negedge clk);
    data_in = 8'h78;
    @(posedge clk); #1;
    check("mid_re_pc", pc, 16'h7856);
    check("mid_re_ready", {15'h0, ready}, 16'h0001);
    check("mid_re_dir", dir_addr, 16'h0000);
    @(negedge clk);
    set_ctl(0, 0, 0, 0, 0, 0, 0);

    // Randomized run against the reference model, with occasional resets
    m_phase = 0;
    m_pc = 16'h0000;
    m_op = 8'hEA; m_dl = 8'h00; m_dh = 8'h00; m_xl = 8'h00; m_xh = 8'h00;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      rst = (k == 0 || $urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      data_in = 8'($urandom_range(0, 255));
      set_ctl($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 1) == 1);
      if (!rst) begin
        m_phase = 0;
        m_pc = 16'h0000;
        m_op = 8'hEA; m_dl = 8'h00; m_dh = 8'h00; m_xl = 8'h00; m_xh = 8'h00;
      end
      #1;
      check("rnd_addr", address, model_addr(address_select));
      check("rnd_ready", {15'h0, ready}, {15'h0, (m_phase >= 2)});
      check("rnd_opcode", {8'h00, opcode}, {8'h00, data_in});
      @(posedge clk);
      if (rst) begin
        if (m_phase == 0) begin
          m_pc = 16'((m_pc / 256) * 256 + data_in);
          m_phase = 1;
        end else if (m_phase == 1) begin
          m_pc = 16'(data_in * 256 + (m_pc % 256));
          m_phase = 2;
        end else begin
          if (increment_pc)     m_pc = 16'((int'(m_pc) + 1) % 65536);
          if (instruction_load) m_op = data_in;
          if (dirl_load)        m_dl = data_in;
          if (dirh_load)        m_dh = data_in;
          if (indirl_load)      m_xl = data_in;
          if (indirh_load)      m_xh = data_in;
        end
      end
      #1;
      check("rnd_pc", pc, m_pc);
      check("rnd_op", {8'h00, opcode_reg}, {8'h00, m_op});
      check("rnd_dir", dir_addr, {m_dh, m_dl});
      check("rnd_ind", indir_addr, {m_xh, m_xl});
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
